// File: rtl/column_iter_scheduler_if.sv
// Handshake bundle between the column-iteration scheduler and its
// surroundings (column array flags, HPS run control, VGA snapshot readout).
interface column_iter_scheduler_if #(
  parameter int NUM_COLS  = 16,
  parameter int ITER_BITS = 16
);
  logic                 run;
  logic                 step_req;
  logic [NUM_COLS-1:0]  col_flags;
  logic [ITER_BITS-1:0] iter_limit;
  logic [7:0]           snap_period;
  logic                 snap_ack;
  logic                 start;
  logic                 snap_req;
  logic [ITER_BITS-1:0] iter_count;
  logic                 busy;
  logic                 paused;
  logic                 done;
  logic                 error;

  // Control / column side: drives requests and flags, observes status.
  modport master (
    output run, step_req, col_flags, iter_limit, snap_period, snap_ack,
    input  start, snap_req, iter_count, busy, paused, done, error
  );

  // Scheduler side.
  modport slave (
    input  run, step_req, col_flags, iter_limit, snap_period, snap_ack,
    output start, snap_req, iter_count, busy, paused, done, error
  );
endinterface

// File: rtl/column_iter_scheduler.sv
// Iteration sequencer for the heat-grid column engines: waits for every
// column flag, optionally holds for a VGA snapshot, enforces an iteration
// limit and a hang watchdog, then broadcasts a one-cycle start pulse.
module column_iter_scheduler #(
  parameter int NUM_COLS  = 16,
  parameter int ITER_BITS = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                     clk,
  input  logic                     reset,  // asynchronous, active low
  column_iter_scheduler_if.slave   bus
);

  localparam int WD_BITS = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_DONE, EVAL, SNAP, GATE, FIRE, WAIT_CLR, HALT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ITER_BITS-1:0] r_iter_count;
  logic [7:0]           r_snap_cnt;
  logic [WD_BITS-1:0]   r_wdog;
  logic                 r_error;
  logic                 r_start;
  logic                 r_snap_req;
  logic                 r_busy;
  logic                 r_paused;
  logic                 r_done;

  logic w_all_flags;
  logic w_no_flags;
  logic w_wd_expired;
  logic w_limit_hit;
  logic w_iter_inc;
  logic w_snap_clr;
  logic w_err_set;
  logic w_done_set;

  assign w_all_flags  = &bus.col_flags;
  assign w_no_flags   = ~|bus.col_flags;
  // Counter holds 0..TIMEOUT-1, so expiry lands on the TIMEOUT-th cycle.
  assign w_wd_expired = (r_wdog == WD_BITS'(TIMEOUT - 1));
  assign w_limit_hit  = (bus.iter_limit != '0) && (r_iter_count >= bus.iter_limit);

  // Next-state and one-cycle action decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    w_next     = r_state;
    w_iter_inc = 1'b0;
    w_snap_clr = 1'b0;
    w_err_set  = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_error && bus.run) w_next = w_all_flags ? GATE : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_all_flags) begin
          w_iter_inc = 1'b1;
          w_next     = EVAL;
        end else if (w_wd_expired) begin
          w_err_set = 1'b1;
          w_next    = HALT;
        end
      end
      EVAL: begin
        if (bus.snap_period != 8'd0 && r_snap_cnt == bus.snap_period) begin
          w_snap_clr = 1'b1;
          w_next     = SNAP;
        end else begin
          w_next = GATE;
        end
      end
      SNAP: begin
        if (bus.snap_ack) w_next = GATE;
      end
      GATE: begin
        if (w_limit_hit) begin
          w_done_set = 1'b1;
          w_next     = HALT;
        end else if (bus.run || bus.step_req) begin
          w_next = FIRE;
        end
      end
      FIRE: w_next = WAIT_CLR;
      WAIT_CLR: begin
        // Flags must all drop before counting again, so stale flags from
        // the previous iteration are never re-counted.
        if (w_no_flags) begin
          w_next = WAIT_DONE;
        end else if (w_wd_expired) begin
          w_err_set = 1'b1;
          w_next    = HALT;
        end
      end
      HALT: begin
        if (!bus.run) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset aborts any iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_iter_count <= '0;
      r_snap_cnt   <= '0;
      r_wdog       <= '0;
      r_error      <= 1'b0;
      r_start      <= 1'b0;
      r_snap_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_paused     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      r_state <= w_next;

      if (w_next != r_state)                              r_wdog <= '0;
      else if (r_state == WAIT_DONE || r_state == WAIT_CLR) r_wdog <= r_wdog + 1'b1;

      if (w_iter_inc) r_iter_count <= r_iter_count + 1'b1;

      if (w_snap_clr)      r_snap_cnt <= '0;
      else if (w_iter_inc) r_snap_cnt <= r_snap_cnt + 1'b1;

      r_error    <= r_error | w_err_set;
      r_done     <= w_done_set;
      r_start    <= (w_next == FIRE);
      r_snap_req <= (w_next == SNAP);
      r_busy     <= (w_next == WAIT_DONE) || (w_next == EVAL) || (w_next == SNAP)
                 || (w_next == FIRE)      || (w_next == WAIT_CLR);
      // A GATE visit with run=1 fires on the following edge, so it is not a pause.
      r_paused   <= (w_next == GATE) && !bus.run;
    end
  end

  assign bus.start      = r_start;
  assign bus.snap_req   = r_snap_req;
  assign bus.iter_count = r_iter_count;
  assign bus.busy       = r_busy;
  assign bus.paused     = r_paused;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_column_iter_scheduler.sv
// Directed bench for column_iter_scheduler with a behavioural column model:
// columns clear their flags on seeing start and raise them 10 cycles later.
module tb_column_iter_scheduler;
  localparam int NC = 4;
  localparam int IB = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  column_iter_scheduler_if #(.NUM_COLS(NC), .ITER_BITS(IB)) bus ();

  column_iter_scheduler #(.NUM_COLS(NC), .ITER_BITS(IB), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Column array model; col_en masks columns that never finish.
  logic [NC-1:0] m_flags;
  logic [NC-1:0] col_en;
  int            m_cnt;
  int            rise_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      m_flags <= '0;
      m_cnt   <= 3;
    end else if (bus.start === 1'b1) begin
      m_flags <= '0;
      m_cnt   <= 10;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_flags  <= '1;
        rise_cyc <= cyc;
      end
    end
  end

  assign bus.col_flags = m_flags & col_en;

  // Event monitors.
  int   start_cnt   = 0;
  int   done_cnt    = 0;
  int   overlap_cnt = 0;
  int   snap_rise   = 0;
  logic snap_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.start === 1'b1) start_cnt <= start_cnt + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.start === 1'b1 && bus.snap_req === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (bus.snap_req === 1'b1 && snap_prev !== 1'b1) snap_rise <= snap_rise + 1;
    snap_prev <= bus.snap_req;
  end

  // Wait (bounded) on a DUT output: 0 start, 1 done, 2 paused, 3 snap_req, 4 error.
  task automatic wait_sig(input int sel, input int budget, output bit found);
    logic v;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0:       v = bus.start;
        1:       v = bus.done;
        2:       v = bus.paused;
        3:       v = bus.snap_req;
        default: v = bus.error;
      endcase
      if (v === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.run         = 1'b0;
    bus.step_req    = 1'b0;
    bus.iter_limit  = '0;
    bus.snap_period = '0;
    bus.snap_ack    = 1'b0;
    col_en          = '1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.run         = 1'b0;
    bus.step_req    = 1'b0;
    bus.iter_limit  = '0;
    bus.snap_period = '0;
    bus.snap_ack    = 1'b0;
    col_en          = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.start, bus.snap_req, bus.busy, bus.paused, bus.done, bus.error} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.start, bus.snap_req, bus.busy, bus.paused, bus.done, bus.error});
    else n_pass++;
    n_checks++;
    if (bus.iter_count !== 16'd0)
      $display("FAIL reset_iter_count: got %0d expected 0", bus.iter_count);
    else n_pass++;
    #2 reset = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.start !== 1'b0)
      $display("FAIL idle_no_run: busy=%b start=%b expected 0 0", bus.busy, bus.start);
    else n_pass++;
  endtask

  task automatic test_free_run();
    bit found;
    do_reset();
    bus.run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_sig(0, 60, found);
      n_checks++;
      if (!found) $display("FAIL free_start_seen it%0d: no start in 60 cycles, expected one", k);
      else n_pass++;
      n_checks++;
      if (cyc - rise_cyc !== 3)
        $display("FAIL free_latency it%0d: got %0d cycles expected 3", k, cyc - rise_cyc);
      else n_pass++;
      n_checks++;
      if (bus.iter_count !== 16'(k))
        $display("FAIL free_iter_count it%0d: got %0d expected %0d", k, bus.iter_count, k);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.start !== 1'b0)
        $display("FAIL free_start_width it%0d: start=%b one cycle later, expected 0", k, bus.start);
      else n_pass++;
    end
  endtask

  task automatic test_limit();
    bit found;
    int s0, d0, s1, c0;
    do_reset();
    s0 = start_cnt;
    d0 = done_cnt;
    bus.iter_limit = 16'd5;
    bus.run        = 1'b1;
    wait_sig(1, 400, found);
    n_checks++;
    if (!found) $display("FAIL limit_done_seen: no done in 400 cycles, expected one");
    else n_pass++;
    n_checks++;
    if (bus.iter_count !== 16'd5)
      $display("FAIL limit_count_at_done: got %0d expected 5", bus.iter_count);
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 !== 4)
      $display("FAIL limit_start_pulses: got %0d expected 4", start_cnt - s0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL limit_halt: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (start_cnt - s0 !== 4 || done_cnt - d0 !== 1)
      $display("FAIL limit_halt_stays: starts=%0d dones=%0d expected 4 1",
               start_cnt - s0, done_cnt - d0);
    else n_pass++;

    #2 bus.run = 1'b0;
    repeat (3) @(negedge clk);
    s1 = start_cnt;
    #2 bus.iter_limit = 16'd7;
    bus.run = 1'b1;
    c0 = cyc;
    wait_sig(0, 10, found);
    n_checks++;
    if (!found || cyc - c0 !== 2)
      $display("FAIL resume_gate_direct: found=%b latency=%0d expected 1 2", found, cyc - c0);
    else n_pass++;
    n_checks++;
    if (bus.iter_count !== 16'd5)
      $display("FAIL resume_no_recount: got %0d expected 5", bus.iter_count);
    else n_pass++;
    wait_sig(1, 200, found);
    n_checks++;
    if (!found || bus.iter_count !== 16'd7)
      $display("FAIL resume_done: found=%b count=%0d expected 1 7", found, bus.iter_count);
    else n_pass++;
    n_checks++;
    if (start_cnt - s1 !== 2)
      $display("FAIL resume_start_pulses: got %0d expected 2", start_cnt - s1);
    else n_pass++;
  endtask

  task automatic test_snapshot();
    bit found;
    int sr0, ov0, sc;
    do_reset();
    sr0 = snap_rise;
    ov0 = overlap_cnt;
    bus.snap_period = 8'd3;
    bus.run         = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      wait_sig(3, 200, found);
      n_checks++;
      if (!found || bus.iter_count !== 16'(3 * k))
        $display("FAIL snap_req_at_iter k%0d: found=%b count=%0d expected 1 %0d",
                 k, found, bus.iter_count, 3 * k);
      else n_pass++;
      sc = start_cnt;
      repeat (20) @(negedge clk);
      n_checks++;
      if (bus.snap_req !== 1'b1 || start_cnt !== sc)
        $display("FAIL snap_hold k%0d: snap_req=%b starts=%0d expected 1 0",
                 k, bus.snap_req, start_cnt - sc);
      else n_pass++;
      #2 bus.snap_ack = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.snap_req !== 1'b0)
        $display("FAIL snap_release k%0d: snap_req=%b expected 0", k, bus.snap_req);
      else n_pass++;
      #2 bus.snap_ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.start !== 1'b1)
        $display("FAIL snap_start_after_ack k%0d: start=%b expected 1", k, bus.start);
      else n_pass++;
    end
    wait_sig(0, 60, found);
    wait_sig(0, 60, found);
    @(negedge clk);
    n_checks++;
    if (snap_rise - sr0 !== 2 || overlap_cnt - ov0 !== 0 || bus.iter_count !== 16'd8)
      $display("FAIL snap_totals: snaps=%0d overlaps=%0d count=%0d expected 2 0 8",
               snap_rise - sr0, overlap_cnt - ov0, bus.iter_count);
    else n_pass++;
  endtask

  task automatic test_pause_step();
    bit found;
    int sc;
    do_reset();
    bus.run = 1'b1;
    wait_sig(0, 60, found);
    #2 bus.run = 1'b0;
    wait_sig(2, 60, found);
    n_checks++;
    if (!found || bus.iter_count !== 16'd2 || bus.busy !== 1'b0)
      $display("FAIL pause_entry: found=%b count=%0d busy=%b expected 1 2 0",
               found, bus.iter_count, bus.busy);
    else n_pass++;
    sc = start_cnt;
    repeat (15) @(negedge clk);
    n_checks++;
    if (start_cnt !== sc || bus.paused !== 1'b1)
      $display("FAIL pause_hold: starts=%0d paused=%b expected 0 1", start_cnt - sc, bus.paused);
    else n_pass++;
    #2 bus.step_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.start !== 1'b1 || bus.paused !== 1'b0)
      $display("FAIL step_fire: start=%b paused=%b expected 1 0", bus.start, bus.paused);
    else n_pass++;
    #2 bus.step_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1)
      $display("FAIL step_in_flight: busy=%b expected 1", bus.busy);
    else n_pass++;
    #2 bus.step_req = 1'b1;
    @(negedge clk);
    #2 bus.step_req = 1'b0;
    wait_sig(2, 40, found);
    n_checks++;
    if (!found || bus.iter_count !== 16'd3)
      $display("FAIL step_repause: found=%b count=%0d expected 1 3", found, bus.iter_count);
    else n_pass++;
    sc = start_cnt;
    repeat (15) @(negedge clk);
    n_checks++;
    if (start_cnt !== sc || bus.paused !== 1'b1 || bus.iter_count !== 16'd3)
      $display("FAIL step_ignored_outside_gate: starts=%0d paused=%b count=%0d expected 0 1 3",
               start_cnt - sc, bus.paused, bus.iter_count);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    bit found;
    int wb, sc;
    do_reset();
    col_en  = 4'b1110;
    bus.run = 1'b1;
    wb      = 0;
    found   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.error === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) wb++;
    end
    n_checks++;
    if (!found || wb !== TO)
      $display("FAIL wdog_timeout: error_seen=%b wait_cycles=%0d expected 1 %0d", found, wb, TO);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL wdog_halt: busy=%b expected 0", bus.busy);
    else n_pass++;
    col_en = '1;
    #2 bus.run = 1'b0;
    repeat (3) @(negedge clk);
    sc = start_cnt;
    #2 bus.run = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (start_cnt !== sc || bus.error !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL wdog_sticky: starts=%0d error=%b busy=%b expected 0 1 0",
               start_cnt - sc, bus.error, bus.busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    bus.snap_period = 8'd1;
    bus.run         = 1'b1;
    wait_sig(3, 100, found);
    n_checks++;
    if (!found || bus.busy !== 1'b1)
      $display("FAIL areset_pre_snap: snap_seen=%b busy=%b expected 1 1", found, bus.busy);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.snap_req, bus.start, bus.busy, bus.error} !== 4'b0 || bus.iter_count !== 16'd0)
      $display("FAIL areset_immediate: snap_req/start/busy/error=%b count=%0d expected 0000 0",
               {bus.snap_req, bus.start, bus.busy, bus.error}, bus.iter_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_limit();
    test_snapshot();
    test_pause_step();
    test_watchdog();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/column_iter_scheduler.md
Name: column_iter_scheduler

Overview:
- Iteration sequencer for the array of heat-grid column engines.
- Each iteration it:
  - collects every column's per-iteration `flag`;
  - optionally pauses so the VGA readout can take a consistent snapshot;
  - enforces an iteration limit and a hang watchdog;
  - broadcasts the single-cycle `start` pulse that releases all columns into the next iteration.
- Sits between the column array and the HPS/VGA control logic.

Parameters:
- NUM_COLS, 16, number of column engines (width of the flag vector).
- ITER_BITS, 16, width of the iteration counter and the limit.
- TIMEOUT, 4096, max cycles allowed in WAIT_DONE or WAIT_CLR before error.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  asynchronous, active-low reset (0 = reset).
- run  input  1  level; 1 = free-run iterations, 0 = pause at GATE.
- step_req  input  1  one-cycle pulse; while paused, fires exactly one iteration.
- col_flags  input  NUM_COLS  per-column `flag` (high = column finished the current iteration and waiting).
- iter_limit  input  ITER_BITS  halt when iter_count >= iter_limit; 0 = unlimited.
- snap_period  input  8  request a snapshot every snap_period iterations; 0 = never.
- snap_ack  input  1  readout done; releases SNAP.
- start  output  1  broadcast to all columns' `start`.
- snap_req  output  1  snapshot request to VGA readout.
- iter_count  output  ITER_BITS  completed iterations.
- busy  output  1  iteration in flight (WAIT_DONE, EVAL, SNAP, FIRE, WAIT_CLR).
- paused  output  1  state == GATE and not firing.
- done  output  1  one-cycle pulse on reaching iter_limit.
- error  output  1  sticky watchdog error.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all outputs 0; iter_count=0; snap_cnt=0; watchdog=0.
  - Reset mid-iteration aborts immediately; columns are not reset by this block.
- All outputs are registered.
- IDLE:
  - run=1 and &col_flags → GATE (columns already parked, e.g. resume after HALT).
  - run=1 otherwise → WAIT_DONE.
- WAIT_DONE:
  - watchdog counts each cycle.
  - &col_flags=1 → iter_count+1 (wraps at 2^ITER_BITS), snap_cnt+1, watchdog=0 → EVAL.
  - watchdog reaches TIMEOUT → error=1 → HALT.
- EVAL (1 cycle):
  - snap_period≠0 and snap_cnt+1 already == snap_period → snap_cnt=0, snap_req=1 → SNAP.
  - otherwise → GATE.
- SNAP:
  - hold snap_req=1 and start=0 until snap_ack=1.
  - On ack: snap_req=0 next cycle → GATE.
  - No watchdog in SNAP.
- GATE:
  - iter_limit≠0 and iter_count >= iter_limit → done pulse → HALT.
  - else run=1, or (run=0 and step_req=1) → FIRE.
  - else stay (paused=1).
  - step_req outside GATE is ignored.
- FIRE:
  - start=1 for exactly this one cycle → WAIT_CLR.
- WAIT_CLR:
  - columns clear `flag` the cycle after they see start; wait until col_flags==0 → WAIT_DONE.
  - watchdog active; timeout → error, HALT.
  - Prevents re-counting stale flags.
- HALT:
  - start=0, busy=0; stays while run=1.
  - run=0 → IDLE; iter_count is retained.
- Latency:
  - all-flags-high sampled at cycle T → start high at T+3 (no snapshot, run=1).
  - Minimum iteration overhead: 3 cycles plus WAIT_CLR.
- Partial flags (some high) never advance state.
- Flags that rise and fall without all being high simultaneously are not counted.
- snap_req and start are never high in the same cycle.
- error clears only on reset; while error=1, IDLE stays IDLE regardless of run.

Test Plan:
- Free-run:
  - Stimulus: NUM_COLS=4, run=1, iter_limit=0, snap_period=0; model columns raise flags 10 cycles after start and drop 1 cycle after start.
  - Required: start pulses 1 cycle wide; start high exactly 3 cycles after flags reach 4'b1111; iter_count increments once per iteration.
- Limit:
  - Stimulus: iter_limit=5.
  - Required: exactly 4 start pulses after the first completion; done pulses once when iter_count=5; then HALT with busy=0.
  - Then set run=0 → IDLE; iter_limit=7 and run=1 → GATE immediately, 2 more iterations, done at iter_count=7.
- Snapshot:
  - Stimulus: snap_period=3; snap_ack delayed 20 cycles.
  - Required: snap_req high only after iterations 3 and 6; no start while snap_req=1; start 2 cycles after snap_ack.
- Pause/step:
  - Stimulus: run=0 after iteration 2; step_req pulse.
  - Required: paused=1; one start pulse, iter_count→3; paused again; step_req during WAIT_DONE is ignored.
- Watchdog:
  - Stimulus: TIMEOUT=64; one column's flag held low.
  - Required: error=1 on the 64th WAIT_DONE cycle → HALT; start never asserts again until reset.
- Async reset:
  - Stimulus: reset=0 asserted mid-SNAP between clock edges.
  - Required: snap_req, start and busy drop to 0 immediately (before the next edge); iter_count=0.
